// File: rtl/herculesae_vx_aesmix_pipe.sv
// Pipelined AES column-mix unit: MixColumns, InvMixColumns or pass-through
// on LANES independent 128-bit states per beat, valid/ready on both sides.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   flush           synchronous drop of every in-flight beat
//   in_valid/ready  input handshake; in_op selects 00 mix, 01 inv-mix,
//                   10 pass, 11 reserved (pass + out_err)
//   in_data/in_tag  LANES x 128-bit states and side-band tag
//   out_valid/ready output handshake; out_data/out_tag/out_err from last stage
//   busy            any stage holds a valid beat
module herculesae_vx_aesmix_pipe #(
  parameter int unsigned LANES       = 1,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned TAG_W       = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [128*LANES-1:0]   in_data,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [128*LANES-1:0]   out_data,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_err,
  output logic                   busy
);

  localparam int unsigned DW   = 128 * LANES;
  localparam int unsigned LAST = PIPE_STAGES - 1;

  if (LANES < 1 || LANES > 4) begin : g_bad_lanes
    $error("herculesae_vx_aesmix_pipe: LANES must be 1..4");
  end
  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
    $error("herculesae_vx_aesmix_pipe: PIPE_STAGES must be 1..4");
  end

  // Multiply by x in GF(2^8) mod 0x11B.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One 32-bit column, row 0 in the low byte; inv selects InvMixColumns.
  function automatic logic [31:0] mix_col(input logic [31:0] w, input logic inv);
    logic [7:0]  a   [4];
    logic [7:0]  p2  [4];
    logic [7:0]  p4  [4];
    logic [7:0]  p8  [4];
    logic [31:0] res;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      a[r]  = w[8*r +: 8];
      p2[r] = xt(a[r]);
      p4[r] = xt(p2[r]);
      p8[r] = xt(p4[r]);
    end
    for (int r = 0; r < 4; r++) begin
      if (inv) begin
        res[8*r +: 8] = (p8[r] ^ p4[r] ^ p2[r])                    // 14
                      ^ (p8[(r+1)%4] ^ p2[(r+1)%4] ^ a[(r+1)%4])   // 11
                      ^ (p8[(r+2)%4] ^ p4[(r+2)%4] ^ a[(r+2)%4])   // 13
                      ^ (p8[(r+3)%4] ^ a[(r+3)%4]);                // 9
      end else begin
        res[8*r +: 8] = p2[r] ^ (p2[(r+1)%4] ^ a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
      end
    end
    return res;
  endfunction

  logic [DW-1:0]          mixed;
  logic [PIPE_STAGES-1:0] v;
  logic [PIPE_STAGES-1:0] ld;
  logic [PIPE_STAGES-1:0] err_q;
  logic [DW-1:0]          data_q [PIPE_STAGES];
  logic [TAG_W-1:0]       tag_q  [PIPE_STAGES];
  logic                   accept;

  // Column mixing ahead of stage 0; op 1x leaves the data untouched.
  always_comb begin
    mixed = in_data;
    if (!in_op[1]) begin
      for (int l = 0; l < int'(LANES); l++) begin
        for (int c = 0; c < 4; c++) begin
          mixed[128*l + 32*c +: 32] = mix_col(in_data[128*l + 32*c +: 32], in_op[0]);
        end
      end
    end
  end

  // A stage loads when it or any stage downstream of it is empty, or the
  // output is being consumed: this collapses bubbles behind a stall.
  always_comb begin
    logic acc;
    acc = out_ready;
    ld  = '0;
    for (int k = int'(LAST); k >= 0; k--) begin
      acc   = acc || !v[k];
      ld[k] = acc;
    end
  end

  assign in_ready = ld[0] && !flush;
  assign accept   = in_valid && in_ready;

  // Valid and error bits: reset, cleared by flush, shifted on load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v     <= '0;
      err_q <= '0;
    end else begin
      if (flush) begin
        v[0] <= 1'b0;
      end else if (ld[0]) begin
        v[0] <= in_valid;
      end
      if (accept) begin
        err_q[0] <= (in_op == 2'b11);
      end
      for (int k = 1; k < int'(PIPE_STAGES); k++) begin
        if (flush) begin
          v[k] <= 1'b0;
        end else if (ld[k]) begin
          v[k] <= v[k-1];
        end
        if (ld[k] && v[k-1]) begin
          err_q[k] <= err_q[k-1];
        end
      end
    end
  end

  // Payload registers move only with a valid beat and are never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_q[0] <= mixed;
      tag_q[0]  <= in_tag;
    end
    for (int k = 1; k < int'(PIPE_STAGES); k++) begin
      if (ld[k] && v[k-1]) begin
        data_q[k] <= data_q[k-1];
        tag_q[k]  <= tag_q[k-1];
      end
    end
  end

  assign out_valid = v[LAST];
  assign out_data  = data_q[LAST];
  assign out_tag   = tag_q[LAST];
  assign out_err   = err_q[LAST];
  assign busy      = |v;

endmodule

// File: tb/tb_herculesae_vx_aesmix_pipe.sv
// Bench for herculesae_vx_aesmix_pipe: a GF(2^8) matrix reference model and
// an expected-beat queue, checked every cycle by one monitor process.
module tb_herculesae_vx_aesmix_pipe;

  localparam int unsigned LANES = 4;
  localparam int unsigned PS    = 2;
  localparam int unsigned TAG_W = 6;
  localparam int unsigned DW    = 128 * LANES;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_op = 2'b00;
  logic [DW-1:0]    in_data = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DW-1:0]    out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
  logic             busy;

  int checks = 0;
  int errors = 0;
  bit rand_mode = 1'b0;

  typedef struct {
    logic [DW-1:0]    d;
    logic [TAG_W-1:0] t;
    logic             e;
  } beat_t;
  beat_t exp_q[$];

  herculesae_vx_aesmix_pipe #(.LANES(LANES), .PIPE_STAGES(PS), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Carry-less product then reduction by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] ref_col(input logic [31:0] w, input logic inv);
    logic [7:0]  coef [4];
    logic [7:0]  s;
    logic [31:0] r;
    if (inv) coef = '{8'd14, 8'd11, 8'd13, 8'd9};
    else     coef = '{8'd2, 8'd3, 8'd1, 8'd1};
    r = '0;
    for (int row = 0; row < 4; row++) begin
      s = '0;
      for (int j = 0; j < 4; j++) s = s ^ gmul(coef[j], w[8*((row + j) % 4) +: 8]);
      r[8*row +: 8] = s;
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] ref_beat(input logic [1:0] op, input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (!op[1])
      for (int i = 0; i < int'(DW / 32); i++) r[32*i +: 32] = ref_col(d[32*i +: 32], op[0]);
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < int'(DW / 32); i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Present one beat and hold it until the handshake edge has passed.
  task automatic send(input logic [1:0] op, input logic [DW-1:0] d, input logic [TAG_W-1:0] t);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1; in_op = op; in_data = d; in_tag = t;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    chk("send_accepted", DW'(acc), DW'(1));
  endtask

  // Directed beat with unstalled latency and literal result.
  task automatic directed(input string nm, input logic [1:0] op, input logic [DW-1:0] d,
                          input logic [TAG_W-1:0] t, input logic [DW-1:0] exp);
    int n;
    out_ready = 1'b1;
    send(op, d, t);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_latency"}, DW'(n), DW'(PS));
    chk({nm, "_data"}, out_data, exp);
    chk({nm, "_tag"}, DW'(out_tag), DW'(t));
    chk({nm, "_err"}, DW'(out_err), DW'(op == 2'b11));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_idle", DW'(busy), DW'(0));
  endtask

  // Monitor: handshakes are judged mid-cycle, where every input is stable.
  logic             prev_stall = 1'b0;
  logic             prev_flush = 1'b0;
  logic [DW-1:0]    prev_d;
  logic [TAG_W-1:0] prev_t;
  logic             prev_e;
  always @(negedge clk) begin
    beat_t b;
    if (reset) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", DW'(in_ready),
          DW'(!flush && (exp_q.size() < int'(PS) || out_ready)));
      chk("busy", DW'(busy), DW'(exp_q.size() != 0));
      if (prev_stall && !prev_flush) chk("hold_valid", DW'(out_valid), DW'(1));
      if (prev_stall && out_valid) begin
        chk("hold_data", out_data, prev_d);
        chk("hold_tag", DW'(out_tag), DW'(prev_t));
        chk("hold_err", DW'(out_err), DW'(prev_e));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", DW'(out_valid), DW'(0));
        end else begin
          b = exp_q.pop_front();
          chk("out_data", out_data, b.d);
          chk("out_tag", DW'(out_tag), DW'(b.t));
          chk("out_err", DW'(out_err), DW'(b.e));
        end
      end
      if (in_valid && in_ready) begin
        b.d = ref_beat(in_op, in_data);
        b.t = in_tag;
        b.e = (in_op == 2'b11);
        exp_q.push_back(b);
      end
      if (flush) exp_q.delete();
      prev_stall = out_valid && !out_ready;
      prev_flush = flush;
      prev_d = out_data;
      prev_t = out_tag;
      prev_e = out_err;
    end
  end

  // Random back-pressure and occasional flush while rand_mode is on.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_mode) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    int acc_cnt;
    logic a;

    // Model pinned by hand-known columns.
    chk("model_fwd_db", DW'(ref_col(32'h455313db, 1'b0)), DW'(32'hbca14d8e));
    chk("model_inv_db", DW'(ref_col(32'hbca14d8e, 1'b1)), DW'(32'h455313db));
    chk("model_fwd_f2", DW'(ref_col(32'h5c220af2, 1'b0)), DW'(32'h9d58dc9f));
    chk("model_fwd_c6", DW'(ref_col(32'hc6c6c6c6, 1'b0)), DW'(32'hc6c6c6c6));
    chk("model_inv_c6", DW'(ref_col(32'hc6c6c6c6, 1'b1)), DW'(32'hc6c6c6c6));

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", DW'(out_valid), DW'(0));
    chk("reset_busy", DW'(busy), DW'(0));
    chk("reset_out_err", DW'(out_err), DW'(0));
    #2 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", DW'(in_ready), DW'(1));
    @(posedge clk);
    #1;

    directed("mix_db", 2'b00, {(DW/32){32'h455313db}}, 6'h2a, {(DW/32){32'hbca14d8e}});
    directed("inv_db", 2'b01, {(DW/32){32'hbca14d8e}}, 6'h15, {(DW/32){32'h455313db}});
    directed("mix_f2", 2'b00, {(DW/32){32'h5c220af2}}, 6'h01, {(DW/32){32'h9d58dc9f}});
    directed("mix_c6", 2'b00, {(DW/32){32'hc6c6c6c6}}, 6'h3f, {(DW/32){32'hc6c6c6c6}});
    directed("inv_c6", 2'b01, {(DW/32){32'hc6c6c6c6}}, 6'h00, {(DW/32){32'hc6c6c6c6}});
    directed("lanes", 2'b00,
             {{4{32'h01010101}}, {4{32'hc6c6c6c6}}, {4{32'h5c220af2}}, {4{32'h455313db}}},
             6'h22,
             {{4{32'h01010101}}, {4{32'hc6c6c6c6}}, {4{32'h9d58dc9f}}, {4{32'hbca14d8e}}});
    x = rand_data();
    directed("pass", 2'b10, x, 6'h0a, x);
    directed("reserved", 2'b11, x, 6'h0b, x);

    // Forward then inverse must return the original state.
    for (int i = 0; i < 20; i++) begin
      x = rand_data();
      y = ref_beat(2'b00, x);
      chk("model_roundtrip", ref_beat(2'b01, y), x);
      send(2'b00, x, TAG_W'($urandom));
      send(2'b01, y, TAG_W'($urandom));
      send(2'b10, x, TAG_W'($urandom));
      send(2'b11, x, TAG_W'($urandom));
    end
    wait_idle();

    // Stall: exactly PS beats fit, outputs hold, then drain in order.
    out_ready = 1'b0;
    acc_cnt = 0;
    in_valid = 1'b1; in_op = 2'($urandom_range(0, 3)); in_data = rand_data(); in_tag = TAG_W'($urandom);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a = in_ready;
      @(posedge clk);
      #1;
      if (a) begin
        acc_cnt++;
        in_op = 2'($urandom_range(0, 3)); in_data = rand_data(); in_tag = TAG_W'($urandom);
      end
    end
    chk("stall_accept_count", DW'(acc_cnt), DW'(PS));
    @(negedge clk);
    chk("stall_in_ready", DW'(in_ready), DW'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    // Asynchronous reset with two beats in flight.
    out_ready = 1'b0;
    send(2'b00, rand_data(), 6'h11);
    send(2'b01, rand_data(), 6'h12);
    chk("pre_reset_out_valid", DW'(out_valid), DW'(1));
    #2 reset = 1'b1;
    #1;
    chk("async_reset_out_valid", DW'(out_valid), DW'(0));
    chk("async_reset_busy", DW'(busy), DW'(0));
    @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_midreset", DW'(in_ready), DW'(1));
    @(posedge clk);
    #1;

    // Flush with a concurrent input: both beats and the input are dropped.
    send(2'b00, rand_data(), 6'h21);
    send(2'b00, rand_data(), 6'h22);
    flush = 1'b1; in_valid = 1'b1; in_data = rand_data();
    @(negedge clk);
    chk("flush_in_ready", DW'(in_ready), DW'(0));
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", DW'(out_valid), DW'(0));
    chk("flush_busy", DW'(busy), DW'(0));

    // Flush together with an output handshake: that beat still completes.
    send(2'b01, rand_data(), 6'h31);
    send(2'b10, rand_data(), 6'h32);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; out_ready = 1'b0;
    chk("flush_hs_out_valid", DW'(out_valid), DW'(0));
    chk("flush_hs_busy", DW'(busy), DW'(0));

    // Random traffic with back-pressure and flushes.
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) send(2'($urandom_range(0, 3)), rand_data(), TAG_W'($urandom));
    rand_mode = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/herculesae_vx_aesmix_pipe.md
Name: herculesae_vx_aesmix_pipe

Overview:
Parametrised, pipelined AES column-mix unit; successor to the single-block combinational inverse-mix datapath in the vector execute cluster. Performs forward MixColumns, InvMixColumns or pass-through on LANES independent 128-bit states per beat. Uses a valid/ready handshake with per-stage bubble collapsing and a side-band tag, and sits between the AES SubBytes/ShiftRows stage and vector writeback.

Parameters:
LANES, 1, number of 128-bit AES states per beat (1..4)
PIPE_STAGES, 2, register stages from input to output (1..4); also the latency when unstalled
TAG_W, 6, width of the side-band tag carried alongside the data

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous clear of all in-flight beats
in_valid  input  1  input beat valid
in_ready  output  1  unit can accept an input beat this cycle
in_op  input  2  operation: 00 MixColumns, 01 InvMixColumns, 10 pass-through, 11 reserved
in_data  input  128*LANES  input states; lane L occupies bits [128L+127:128L]
in_tag  input  TAG_W  opaque tag
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts the output beat
out_data  output  128*LANES  result states
out_tag  output  TAG_W  tag travelling with the beat
out_err  output  1  beat was issued with reserved op 11
busy  output  1  any pipeline stage holds a valid beat

Behaviour:
- Byte layout per lane: byte b = bits [8b+7:8b]. Column c = bytes 4c..4c+3; row r of column c = byte 4c+r. Row 0 is the lowest byte of each 32-bit word.
- MixColumns: s_r = 2·a_r ^ 3·a_(r+1) ^ a_(r+2) ^ a_(r+3), indices mod 4.
- InvMixColumns: s_r = 14·a_r ^ 11·a_(r+1) ^ 13·a_(r+2) ^ 9·a_(r+3).
- All multiplies are in GF(2^8) with reduction polynomial 0x11B. The result is exactly 8 bits per byte; no carry out.
- Pass-through (10): data is unchanged.
- Reserved (11): data passes through unchanged and out_err = 1 for that beat.
- Mixing logic is combinational between the input and stage-0 registers. Stages 1..PIPE_STAGES-1 delay data, tag, op-error and valid only.
- Each stage k holds v[k]. Stage k loads when (!v[k] || advance[k+1]). The last stage advances when out_ready.
- in_ready = stage-0 load condition && !flush. Transfer occurs when in_valid && in_ready.
- out_valid = v[PIPE_STAGES-1]. out_data, out_tag and out_err are driven directly from last-stage registers.
- Holding rule: while out_valid && !out_ready, all output signals hold stable.
- Unstalled latency is exactly PIPE_STAGES cycles from input acceptance to out_valid. Throughput is 1 beat/cycle.
- Bubble collapsing: an empty stage accepts a beat even when the stage after it is stalled. At most PIPE_STAGES beats can be in flight.
- Data and tag registers are loaded only on transfer and are not reset. Valid bits are reset.
- Reset (asynchronous, any time, including mid-operation): all v[k] = 0, so out_valid = 0, out_err = 0 and busy = 0. On the first cycle after deassertion, in_ready = 1.
- flush = 1: every v[k] clears at the next edge and in_ready = 0 in that cycle.
  - flush with in_valid: the input is dropped.
  - flush with an output handshake in the same cycle: the handshake still completes (downstream consumed it); the beat is gone afterwards.
- busy = OR of all v[k].
- Lanes are fully independent. in_op applies to all lanes of a beat.
- Illegal parameter values (LANES or PIPE_STAGES out of range) cause an elaboration-time error.

Test Plan:
- LANES=1, PIPE_STAGES=2, op 00: every column word 32'h455313db -> every output word 32'hbca14d8e; out_valid exactly 2 cycles after acceptance; tag 0x2A is returned unchanged.
- Op 01 on column 32'hbca14d8e -> 32'h455313db. Op 00 on 32'h5c220af2 -> 32'h9d58dc9f. Column 32'hc6c6c6c6 maps to itself under 00 and 01.
- Random 128-bit states, op 00 then 01 on the result -> original data returned; op 10 -> identity; op 11 -> identity with out_err=1.
- Hold out_ready=0 with continuous in_valid:
  - exactly PIPE_STAGES beats are accepted, then in_ready=0;
  - outputs stay stable while stalled;
  - after release, beats drain in order with no loss or duplication.
- LANES=4: different states and values per lane -> each lane result matches its own reference; no cross-lane leakage.
- Assert reset mid-stream with 2 beats in flight -> out_valid and busy go 0 immediately (asynchronously), and in_ready=1 after release. Repeat with flush: the beats are discarded, and a concurrent in_valid is not accepted.
